// File: rtl/piece_dispatcher.sv
// piece_dispatcher: sequences Tetris piece spawning. A free-running LFSR feeds a
// 7-bag randomizer that fills a 3-deep preview queue. Pieces are issued to the
// board controller on request, and a blocked spawn latches game-over until the
// next start pulse.
module piece_dispatcher #(
    parameter int          MaxTypeNum = 7,
    parameter logic [3:0]  SpawnX     = 4'd3,
    parameter logic [3:0]  SpawnY     = 4'd0,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        req,
    input  logic        spawn_blocked,
    output logic        ready,
    output logic        valid,
    output logic [3:0]  square_x,
    output logic [3:0]  square_y,
    output logic [2:0]  square_type,
    output logic [2:0]  next_type,
    output logic        game_over,
    output logic [15:0] pieces_issued
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READY = 3'd2,
        ST_ISSUE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Number of types not yet drawn from the current bag.
    function automatic logic [3:0] free_count(input logic [MaxTypeNum-1:0] mask);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < MaxTypeNum; i++) begin
            cnt = cnt + {3'd0, ~mask[i]};
        end
        return cnt;
    endfunction

    // Index of the k-th clear bit of the mask, counting from bit 0.
    function automatic logic [2:0] kth_free(input logic [MaxTypeNum-1:0] mask,
                                            input logic [3:0]            k);
        logic [2:0] sel;
        logic [3:0] seen;
        sel  = 3'd0;
        seen = 4'd0;
        for (int i = 0; i < MaxTypeNum; i++) begin
            if (!mask[i] && (seen == k)) begin
                sel = 3'(i);
            end
            seen = seen + {3'd0, ~mask[i]};
        end
        return sel;
    endfunction

    logic                  rst_meta_q;
    logic                  rst_sync_n_q;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [MaxTypeNum-1:0] mask_q, mask_d;
    logic [1:0]            fill_cnt_q, fill_cnt_d;
    logic [2:0]            q0_q, q0_d;
    logic [2:0]            q1_q, q1_d;
    logic [2:0]            q2_q, q2_d;
    logic [3:0]            sq_x_q, sq_x_d;
    logic [3:0]            sq_y_q, sq_y_d;
    logic [2:0]            sq_type_q, sq_type_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  game_over_q, game_over_d;

    logic [3:0]            free_s;
    logic [3:0]            k_s;
    logic [2:0]            draw_s;
    logic [MaxTypeNum-1:0] mask_set_s;
    logic [MaxTypeNum-1:0] mask_drawn_s;
    logic                  shift_s;
    logic                  issue_s;

    // Reset synchronizer: assertion is immediate, release waits two clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    // Bag draw datapath: pick the (lfsr mod free)-th unused type, refill when empty.
    always_comb begin
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        free_s       = free_count(mask_q);
        if (free_s == 4'd0) begin
            k_s = 4'd0;
        end else begin
            k_s = 4'(lfsr_q[7:0] % {4'd0, free_s});
        end
        draw_s       = kth_free(mask_q, k_s);
        mask_set_s   = mask_q | ({{(MaxTypeNum-1){1'b0}}, 1'b1} << draw_s);
        if (&mask_set_s) begin
            mask_drawn_s = '0;
        end else begin
            mask_drawn_s = mask_set_s;
        end
    end

    // Sequencer next-state: start always restarts; otherwise fill, serve requests, detect top-out.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        fill_cnt_d = fill_cnt_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        sq_x_d     = sq_x_q;
        sq_y_d     = sq_y_q;
        sq_type_d  = sq_type_q;
        cnt_d      = cnt_q;
        shift_s    = 1'b0;
        issue_s    = 1'b0;

        if (start) begin
            state_d    = ST_FILL;
            mask_d     = '0;
            cnt_d      = 16'd0;
            fill_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FILL: begin
                    shift_s = 1'b1;
                    if (fill_cnt_q == 2'd2) begin
                        state_d = ST_READY;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 2'd1;
                    end
                end
                ST_READY: begin
                    if (req) begin
                        issue_s = 1'b1;
                        shift_s = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_ISSUE: begin
                    if (spawn_blocked) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (shift_s) begin
                q0_d   = q1_q;
                q1_d   = q2_q;
                q2_d   = draw_s;
                mask_d = mask_drawn_s;
            end else begin
                mask_d = mask_q;
            end

            if (issue_s) begin
                sq_type_d = q0_q;
                sq_x_d    = SpawnX;
                sq_y_d    = SpawnY;
                cnt_d     = cnt_q + 16'd1;
            end else begin
                cnt_d     = cnt_q;
            end
        end

        ready_d     = (state_d == ST_READY);
        valid_d     = issue_s;
        game_over_d = (state_d == ST_OVER);
    end

    // State and output registers, held in reset until the synchronized release.
    always_ff @(posedge clk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LfsrSeed;
            mask_q      <= '0;
            fill_cnt_q  <= 2'd0;
            q0_q        <= 3'd0;
            q1_q        <= 3'd0;
            q2_q        <= 3'd0;
            sq_x_q      <= 4'd0;
            sq_y_q      <= 4'd0;
            sq_type_q   <= 3'd0;
            cnt_q       <= 16'd0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            mask_q      <= mask_d;
            fill_cnt_q  <= fill_cnt_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            sq_x_q      <= sq_x_d;
            sq_y_q      <= sq_y_d;
            sq_type_q   <= sq_type_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            game_over_q <= game_over_d;
        end
    end

    assign ready         = ready_q;
    assign valid         = valid_q;
    assign square_x      = sq_x_q;
    assign square_y      = sq_y_q;
    assign square_type   = sq_type_q;
    assign next_type     = q0_q;
    assign game_over     = game_over_q;
    assign pieces_issued = cnt_q;

endmodule

// File: tb/tb_piece_dispatcher.sv
// Testbench for piece_dispatcher: reset values, fill timing, 7-bag draws against
// an LFSR/bag reference, back-to-back issue, ignored requests, top-out and restart.
module tb_piece_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        req = 1'b0;
    logic        spawn_blocked = 1'b0;
    logic        ready;
    logic        valid;
    logic [3:0]  square_x;
    logic [3:0]  square_y;
    logic [2:0]  square_type;
    logic [2:0]  next_type;
    logic        game_over;
    logic [15:0] pieces_issued;

    piece_dispatcher dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .req           (req),
        .spawn_blocked (spawn_blocked),
        .ready         (ready),
        .valid         (valid),
        .square_x      (square_x),
        .square_y      (square_y),
        .square_type   (square_type),
        .next_type     (next_type),
        .game_over     (game_over),
        .pieces_issued (pieces_issued)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference LFSR: held at the seed through reset and two release edges.
    logic [15:0] m_lfsr = 16'hACE1;
    int          rel_edges = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr    <= 16'hACE1;
            rel_edges <= 0;
        end else begin
            if (rel_edges >= 2) begin
                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end
            if (rel_edges < 100) begin
                rel_edges <= rel_edges + 1;
            end
        end
    end

    logic [6:0] m_mask = 7'd0;
    logic [2:0] m_q [3] = '{3'd0, 3'd0, 3'd0};

    typedef struct {
        logic        st;
        logic        rq;
        logic        bl;
        logic        e_rdy;
        logic        e_val;
        logic        e_go;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic st, input logic rq, input logic bl,
                                input logic rdy, input logic vl, input logic go,
                                input logic [15:0] cnt);
        vec_t v;
        v.st = st; v.rq = rq; v.bl = bl;
        v.e_rdy = rdy; v.e_val = vl; v.e_go = go; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bag draw using the reference LFSR value of the current cycle.
    task automatic model_draw();
        int         r;
        int         k;
        int         seen;
        logic [2:0] t;
        r = 0;
        for (int i = 0; i < 7; i++) begin
            if (!m_mask[i]) r++;
        end
        k    = int'(m_lfsr[7:0]) % r;
        seen = 0;
        t    = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (!m_mask[i]) begin
                if (seen == k) t = 3'(i);
                seen++;
            end
        end
        m_mask[t] = 1'b1;
        if (m_mask == 7'h7F) m_mask = 7'd0;
        m_q[0] = m_q[1];
        m_q[1] = m_q[2];
        m_q[2] = t;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'(1'b0));
        check({tag, "_valid"}, 32'(valid), 32'(1'b0));
        check({tag, "_x"}, 32'(square_x), 32'(4'd0));
        check({tag, "_y"}, 32'(square_y), 32'(4'd0));
        check({tag, "_type"}, 32'(square_type), 32'(3'd0));
        check({tag, "_next"}, 32'(next_type), 32'(3'd0));
        check({tag, "_game_over"}, 32'(game_over), 32'(1'b0));
        check({tag, "_count"}, 32'(pieces_issued), 32'(16'd0));
    endtask

    // start pulse then three fill cycles; ready must rise exactly at T+4.
    task automatic start_and_fill(input string tag);
        start  = 1'b1;
        m_mask = 7'd0;
        tick();
        start = 1'b0;
        check({tag, "_ready_t1"}, 32'(ready), 32'(1'b0));
        model_draw();
        tick();
        check({tag, "_ready_t2"}, 32'(ready), 32'(1'b0));
        model_draw();
        tick();
        check({tag, "_ready_t3"}, 32'(ready), 32'(1'b0));
        model_draw();
        tick();
        check({tag, "_ready_t4"}, 32'(ready), 32'(1'b1));
        check({tag, "_next_first"}, 32'(next_type), 32'(m_q[0]));
        check({tag, "_count0"}, 32'(pieces_issued), 32'(16'd0));
    endtask

    // From READY with req high: one issue cycle followed by a return to READY.
    task automatic issue_checked(output logic [2:0] t);
        logic [2:0] exp_t;
        exp_t = m_q[0];
        model_draw();
        tick();
        check("issue_valid", 32'(valid), 32'(1'b1));
        check("issue_ready", 32'(ready), 32'(1'b0));
        check("issue_x", 32'(square_x), 32'(4'd3));
        check("issue_y", 32'(square_y), 32'(4'd0));
        check("issue_type", 32'(square_type), 32'(exp_t));
        check("issue_next", 32'(next_type), 32'(m_q[0]));
        t = square_type;
        tick();
        check("gap_valid", 32'(valid), 32'(1'b0));
        check("gap_ready", 32'(ready), 32'(1'b1));
    endtask

    initial begin
        logic [2:0] t;
        logic [6:0] bag_seen;

        // Reset held for three cycles, then released.
        rst = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (4) tick();
        check("idle_ready", 32'(ready), 32'(1'b0));
        check("idle_count", 32'(pieces_issued), 32'(16'd0));
        repeat (3) tick();

        start_and_fill("start");

        // 70 back-to-back requests with req held high.
        req      = 1'b1;
        bag_seen = 7'd0;
        for (int i = 0; i < 70; i++) begin
            issue_checked(t);
            bag_seen = bag_seen | (7'd1 << t);
            if ((i % 7) == 6) begin
                check($sformatf("bag_perm_%0d", i / 7), 32'(bag_seen), 32'(7'h7F));
                bag_seen = 7'd0;
            end
        end
        req = 1'b0;
        check("count_70", 32'(pieces_issued), 32'(16'd70));

        // Table: ignored requests, ignored blocking, top-out, restarts.
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
        vecs[18] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[24] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[27] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        vecs[28] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[29] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[31] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < 32; i++) begin
            start         = vecs[i].st;
            req           = vecs[i].rq;
            spawn_blocked = vecs[i].bl;
            tick();
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_val));
            check($sformatf("vec%0d_game_over", i), 32'(game_over), 32'(vecs[i].e_go));
            check($sformatf("vec%0d_count", i), 32'(pieces_issued), 32'(vecs[i].e_cnt));
        end
        start         = 1'b0;
        req           = 1'b0;
        spawn_blocked = 1'b0;

        // Reset asserted in the second fill cycle: outputs clear at once.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("midfill");
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("post_reset_ready", 32'(ready), 32'(1'b0));

        // Fresh game after reset: full fill and a complete first bag.
        start_and_fill("restart");
        req      = 1'b1;
        bag_seen = 7'd0;
        for (int i = 0; i < 7; i++) begin
            issue_checked(t);
            bag_seen = bag_seen | (7'd1 << t);
        end
        req = 1'b0;
        check("fresh_bag_perm", 32'(bag_seen), 32'(7'h7F));
        check("fresh_count", 32'(pieces_issued), 32'(16'd7));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
